// File: rtl/enemy_pkg.sv
// enemy_pkg: shared types and constants for the enemy motion controller.
// Holds the FSM state enum, coordinate type and sprite strip width.
package enemy_pkg;

   typedef enum logic [2:0] {
      SPAWN,
      WALK_R,
      WALK_L,
      DYING,
      DEAD
   } enemy_state_t;

   localparam int SPRITE_ROW_W = 600;
   localparam int COORD_W      = 11;
   localparam int CNT_W        = 16;

   typedef logic [COORD_W-1:0] coord_t;

   // Counter width that never collapses to zero bits.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/enemy_anim_ctr.sv
// enemy_anim_ctr: walk-cycle animation for one enemy.
// Divides qualified walk ticks by ANIM_DIV and steps a modulo-NUM_FRAMES frame.
module enemy_anim_ctr
   import enemy_pkg::*;
#(
   parameter int NUM_FRAMES = 4,
   parameter int ANIM_DIV   = 8,
   localparam int FW        = cw(NUM_FRAMES)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          tick_en,
   input  logic          clear,
   output logic [FW-1:0] frame
);

   localparam int DW = cw(ANIM_DIV);
   localparam logic [DW-1:0] C_DIV_LAST = DW'(ANIM_DIV - 1);
   localparam logic [FW-1:0] C_FRM_LAST = FW'(NUM_FRAMES - 1);

   logic [DW-1:0] r_div;
   logic [FW-1:0] r_frame;

   // Divider wraps every ANIM_DIV ticks and carries into the frame index.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_div   <= '0;
         r_frame <= '0;
      end else if (tick_en) begin
         if (r_div == C_DIV_LAST) begin
            r_div <= '0;
            if (r_frame == C_FRM_LAST) begin
               r_frame <= '0;
            end else begin
               r_frame <= r_frame + 1'b1;
            end
         end else begin
            r_div <= r_div + 1'b1;
         end
      end
   end

   assign frame = r_frame;

endmodule

// File: rtl/enemy_mover.sv
// enemy_mover: per-enemy patrol, hit, death and respawn controller.
// Optional death animation state enabled by macro ENEMY_DEATH_ANIM_EN.
module enemy_mover
   import enemy_pkg::*;
#(
   parameter int SPRITE_W      = 50,
   parameter int SPRITE_H      = 50,
   parameter int SPAWN_X       = 100,
   parameter int Y_POS         = 400,
   parameter int X_MIN         = 0,
   parameter int X_MAX         = 550,
   parameter int SPEED         = 2,
   parameter int NUM_FRAMES    = 4,
   parameter int ANIM_DIV      = 8,
   parameter int RESPAWN_TICKS = 120,
   parameter int DEATH_TICKS   = 30
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        enable,
   input  logic        hit,
   output logic [10:0] x0,
   output logic [10:0] x1,
   output logic [10:0] y0,
   output logic [10:0] y1,
   output logic [9:0]  sprite_num,
   output logic        visible,
   output logic        alive
);

   localparam int FW = cw(NUM_FRAMES);

   localparam coord_t C_SPRITE_W = coord_t'(SPRITE_W);
   localparam coord_t C_SPRITE_H = coord_t'(SPRITE_H);
   localparam coord_t C_SPAWN_X  = coord_t'(SPAWN_X);
   localparam coord_t C_Y_POS    = coord_t'(Y_POS);
   localparam coord_t C_X_MIN    = coord_t'(X_MIN);
   localparam coord_t C_X_MAX    = coord_t'(X_MAX);
   localparam coord_t C_SPEED    = coord_t'(SPEED);
   localparam coord_t C_L_TURN   = coord_t'(X_MIN + SPEED);
   localparam coord_t C_NF       = coord_t'(NUM_FRAMES);

   localparam logic [CNT_W-1:0] C_RESP_LAST =
      CNT_W'(RESPAWN_TICKS - 1);

`ifdef ENEMY_DEATH_ANIM_EN
   localparam logic [CNT_W-1:0] C_DEATH_LAST =
      CNT_W'(DEATH_TICKS - 1);
   localparam coord_t C_DIE_SN =
      coord_t'(2 * NUM_FRAMES * SPRITE_W);
   localparam enemy_state_t C_HIT_ST = DYING;
`else
   localparam enemy_state_t C_HIT_ST = DEAD;
`endif

   // The whole sprite strip must fit in one ROM row.
   if ((2 * NUM_FRAMES + 1) * SPRITE_W > SPRITE_ROW_W) begin : g_bad_strip
      $error("enemy_mover: sprite strip exceeds ROM row width");
   end

   // Timers must last at least one tick.
   if (RESPAWN_TICKS < 1 || DEATH_TICKS < 1) begin : g_bad_timer
      $error("enemy_mover: timer lengths must be at least 1");
   end

   enemy_state_t     r_state;
   enemy_state_t     w_state_nxt;
   coord_t           r_x0;
   coord_t           w_x0_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_hit_pend;
   logic             w_hit_pend_nxt;

   logic             w_qtick;
   logic             w_walking;
   logic             w_hit;
   logic             w_anim_clr;
   coord_t           w_x0_inc;
   logic [FW-1:0]    w_frame;
   coord_t           w_frame11;
   coord_t           w_sn;

   assign w_qtick   = frame_tick & enable;
   assign w_walking = (r_state == WALK_R) | (r_state == WALK_L);
   assign w_hit     = r_hit_pend | hit;
   assign w_x0_inc  = r_x0 + C_SPEED;
   assign w_frame11 = coord_t'(w_frame);

   // A hit only stays pending while the enemy is hittable.
   assign w_hit_pend_nxt =
      (w_qtick || !w_walking) ? 1'b0 : (r_hit_pend | hit);

   enemy_anim_ctr #(
      .NUM_FRAMES (NUM_FRAMES),
      .ANIM_DIV   (ANIM_DIV)
   ) u_anim (
      .clk     (clk),
      .rst     (rst),
      .tick_en (w_qtick & w_walking),
      .clear   (w_anim_clr),
      .frame   (w_frame)
   );

   // State, position, timer and pending-hit registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= SPAWN;
         r_x0       <= C_SPAWN_X;
         r_cnt      <= '0;
         r_hit_pend <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_x0       <= w_x0_nxt;
         r_cnt      <= w_cnt_nxt;
         r_hit_pend <= w_hit_pend_nxt;
      end
   end

   // Per-tick transitions, movement with edge clamping and timers.
   always_comb begin
      w_state_nxt = r_state;
      w_x0_nxt    = r_x0;
      w_cnt_nxt   = r_cnt;
      w_anim_clr  = 1'b0;
      if (w_qtick) begin
         unique case (r_state)
            SPAWN: begin
               w_state_nxt = WALK_R;
            end
            WALK_R: begin
               if (w_hit) begin
                  w_state_nxt = C_HIT_ST;
                  w_cnt_nxt   = '0;
               end else if (w_x0_inc >= C_X_MAX) begin
                  w_x0_nxt    = C_X_MAX;
                  w_state_nxt = WALK_L;
               end else begin
                  w_x0_nxt = w_x0_inc;
               end
            end
            WALK_L: begin
               if (w_hit) begin
                  w_state_nxt = C_HIT_ST;
                  w_cnt_nxt   = '0;
               end else if (r_x0 <= C_L_TURN) begin
                  w_x0_nxt    = C_X_MIN;
                  w_state_nxt = WALK_R;
               end else begin
                  w_x0_nxt = r_x0 - C_SPEED;
               end
            end
`ifdef ENEMY_DEATH_ANIM_EN
            DYING: begin
               if (r_cnt == C_DEATH_LAST) begin
                  w_state_nxt = DEAD;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
`endif
            DEAD: begin
               if (r_cnt == C_RESP_LAST) begin
                  w_state_nxt = SPAWN;
                  w_x0_nxt    = C_SPAWN_X;
                  w_cnt_nxt   = '0;
                  w_anim_clr  = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            default: begin
               w_state_nxt = SPAWN;
            end
         endcase
      end
   end

   // Visibility, hittability and ROM frame offset from registered state.
   always_comb begin
      visible = 1'b0;
      alive   = 1'b0;
      w_sn    = '0;
      unique case (r_state)
         WALK_R: begin
            visible = 1'b1;
            alive   = 1'b1;
            w_sn    = w_frame11 * C_SPRITE_W;
         end
         WALK_L: begin
            visible = 1'b1;
            alive   = 1'b1;
            w_sn    = (C_NF + w_frame11) * C_SPRITE_W;
         end
`ifdef ENEMY_DEATH_ANIM_EN
         DYING: begin
            visible = 1'b1;
            w_sn    = C_DIE_SN;
         end
`endif
         default: begin
            visible = 1'b0;
         end
      endcase
   end

   assign sprite_num = 10'(w_sn);
   assign x0         = r_x0;
   assign x1         = r_x0 + C_SPRITE_W;
   assign y0         = C_Y_POS;
   assign y1         = C_Y_POS + C_SPRITE_H;

endmodule
